rsa_host_ctrl: RTL and testbench

Host-side initiator for the `exp2_rsa` byte-wide register interface. Accepts commands and 256-bit operands as LSB-first byte streams, drives the write, start and read sequence, waits for the core's `ready` rising edge, and returns the 256-bit result as a backpressured byte stream. Replaces the hand-sequenced stimulus with a reusable synthesizable master that sits between a host bus and the RSA core.

---
 rtl/rsa_host_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_rsa_host_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_host_ctrl.sv
// rsa_host_ctrl: host-side master for the exp2_rsa byte-wide register port.
// Loads 32-byte operands (LSB first), starts the core, waits for the ready
// rising edge and streams the 32-byte result back with backpressure.
// Optional build macro: RSA_HOST_TIMEOUT_EN enables a TIMEOUT_W-bit watchdog
// in WAIT that raises the sticky err flag and abandons the read.
module rsa_host_ctrl #(
  parameter int TIMEOUT_W = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       err,
  output logic       rsa_we,
  output logic       rsa_oe,
  output logic       rsa_start,
  output logic [1:0] rsa_reg_sel,
  output logic [4:0] rsa_addr,
  output logic [7:0] rsa_wdata,
  input  logic [7:0] rsa_rdata,
  input  logic       rsa_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_CAP  = 3'd5,
    S_RD_OUT  = 3'd6
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_op, w_op_nxt;
  logic       r_ready_q;
  logic       w_ready_rise;
  logic       w_we_nxt, w_oe_nxt, w_start_nxt, w_err_nxt;
  logic       w_out_valid_nxt, w_out_last_nxt;
  logic [1:0] w_sel_nxt;
  logic [4:0] w_addr_nxt;
  logic [7:0] w_wdata_nxt, w_out_data_nxt;

`ifdef RSA_HOST_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo, w_tmo_nxt;
  logic                 w_tmo_hit;
  // The increment taking the counter to all-ones is the expiring WAIT cycle.
  assign w_tmo_hit = (r_tmo == ~TIMEOUT_W'(1));
`endif

  // Watchdog width sanity check at elaboration.
  if (TIMEOUT_W < 2) begin : g_tmo_width_chk
    $error("rsa_host_ctrl: TIMEOUT_W must be at least 2");
  end

  // Core register select used by each load opcode.
  function automatic logic [1:0] op_reg_sel(input logic [1:0] op);
    logic [1:0] sel;
    case (op)
      2'd0:    sel = 2'd3;  // modulus
      2'd1:    sel = 2'd2;  // exponent
      default: sel = 2'd1;  // ciphertext for a full run
    endcase
    return sel;
  endfunction

  // Only a low-to-high transition observed by this block completes a run.
  assign w_ready_rise = rsa_ready & ~r_ready_q;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_op_nxt        = r_op;
    w_we_nxt        = 1'b0;
    w_start_nxt     = 1'b0;
    w_oe_nxt        = rsa_oe;
    w_sel_nxt       = rsa_reg_sel;
    w_addr_nxt      = rsa_addr;
    w_wdata_nxt     = rsa_wdata;
    w_out_valid_nxt = out_valid;
    w_out_data_nxt  = out_data;
    w_out_last_nxt  = out_last;
`ifdef RSA_HOST_TIMEOUT_EN
    w_err_nxt       = err;
    w_tmo_nxt       = r_tmo;
`else
    w_err_nxt       = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_op_nxt    = cmd_op;
          w_cnt_nxt   = 5'd0;
          w_err_nxt   = 1'b0;
          w_state_nxt = (cmd_op == 2'd3) ? S_RD_ADDR : S_WRITE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (in_valid) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_cnt;
          w_wdata_nxt = in_data;
          w_sel_nxt   = op_reg_sel(r_op);
          w_cnt_nxt   = r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            w_state_nxt = (r_op == 2'd2) ? S_START : S_IDLE;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_START: begin
        w_start_nxt = 1'b1;
        w_sel_nxt   = 2'd0;
        w_addr_nxt  = 5'd0;
        w_state_nxt = S_WAIT;
`ifdef RSA_HOST_TIMEOUT_EN
        w_tmo_nxt   = '0;
`endif
      end
      S_WAIT: begin
        if (w_ready_rise) begin
          w_state_nxt = S_RD_ADDR;
`ifdef RSA_HOST_TIMEOUT_EN
        end else if (w_tmo_hit) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt   = r_tmo + TIMEOUT_W'(1);
          w_state_nxt = S_WAIT;
`else
        end else begin
          w_state_nxt = S_WAIT;
`endif
        end
      end
      S_RD_ADDR: begin
        // Result register lives at select 0.
        w_oe_nxt    = 1'b1;
        w_sel_nxt   = 2'd0;
        w_addr_nxt  = r_cnt;
        w_state_nxt = S_RD_CAP;
      end
      S_RD_CAP: begin
        w_out_data_nxt  = rsa_rdata;
        w_out_valid_nxt = 1'b1;
        w_out_last_nxt  = (r_cnt == 5'd31);
        w_state_nxt     = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          w_cnt_nxt       = r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RD_ADDR;
          end
        end else begin
          w_state_nxt = S_RD_OUT;
        end
      end
      default: begin
        w_oe_nxt        = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // State, byte counter, latched opcode and watchdog registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_op    <= 2'd0;
`ifdef RSA_HOST_TIMEOUT_EN
      r_tmo   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
`ifdef RSA_HOST_TIMEOUT_EN
      r_tmo   <= w_tmo_nxt;
`endif
    end
  end

  // Delayed copy of the core ready level, sampled every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready_q <= 1'b0;
    end else begin
      r_ready_q <= rsa_ready;
    end
  end

  // Registered outputs; handshake readies follow the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready   <= 1'b1;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      rsa_we      <= 1'b0;
      rsa_oe      <= 1'b0;
      rsa_start   <= 1'b0;
      rsa_reg_sel <= 2'd0;
      rsa_addr    <= 5'd0;
      rsa_wdata   <= 8'd0;
      out_valid   <= 1'b0;
      out_data    <= 8'd0;
      out_last    <= 1'b0;
    end else begin
      cmd_ready   <= (w_state_nxt == S_IDLE);
      in_ready    <= (w_state_nxt == S_WRITE);
      busy        <= (w_state_nxt != S_IDLE);
      err         <= w_err_nxt;
      rsa_we      <= w_we_nxt;
      rsa_oe      <= w_oe_nxt;
      rsa_start   <= w_start_nxt;
      rsa_reg_sel <= w_sel_nxt;
      rsa_addr    <= w_addr_nxt;
      rsa_wdata   <= w_wdata_nxt;
      out_valid   <= w_out_valid_nxt;
      out_data    <= w_out_data_nxt;
      out_last    <= w_out_last_nxt;
    end
  end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// tb_rsa_host_ctrl: randomized self-checking bench for rsa_host_ctrl with a
// behavioural core model (byte memory, ready level) and transaction queues.
module tb_rsa_host_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid, out_ready = 1'b1, out_last;
  logic [7:0] out_data;
  logic       busy, err;
  logic       rsa_we, rsa_oe, rsa_start;
  logic [1:0] rsa_reg_sel;
  logic [4:0] rsa_addr;
  logic [7:0] rsa_wdata, rsa_rdata;
  logic       rsa_ready = 1'b0;

  logic [7:0] core_mem [32];
  logic [7:0] tx [32];

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  logic [14:0] we_q [$];
  int          we_cyc_q [$];
  logic [8:0]  out_q [$];
  int          out_cyc_q [$];
  int start_n = 0, start_cyc = 0, start_viol = 0, oe_seen = 0;
  int mutex_viol = 0, stall_viol = 0;
  bit first_valid_seen = 1'b0;
  int first_valid_cyc = 0;
  bit stall_prev = 1'b0;
  logic [7:0] stall_data = 8'd0;
  logic [4:0] stall_addr = 5'd0;
  int ordy_mode = 0, hold_cnt = 0;
  int acc_edge = 0, rise_cyc = 0;

  // Core read port: data valid combinationally from the presented address.
  assign rsa_rdata = rsa_oe ? core_mem[rsa_addr] : 8'h00;

  rsa_host_ctrl #(.TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err),
    .rsa_we(rsa_we), .rsa_oe(rsa_oe), .rsa_start(rsa_start),
    .rsa_reg_sel(rsa_reg_sel), .rsa_addr(rsa_addr), .rsa_wdata(rsa_wdata),
    .rsa_rdata(rsa_rdata), .rsa_ready(rsa_ready)
  );

  always #5 clk = ~clk;

  // Edge index counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: records core writes, starts, accepted result bytes and protocol violations.
  always @(negedge clk) begin
    if (reset) begin
      if (rsa_we) begin
        we_q.push_back({rsa_reg_sel, rsa_addr, rsa_wdata});
        we_cyc_q.push_back(cyc);
      end
      if (rsa_start) begin
        start_n++;
        start_cyc = cyc;
        if (rsa_we || rsa_reg_sel != 2'd0 || rsa_addr != 5'd0) start_viol++;
      end
      if (rsa_oe) oe_seen++;
      if (out_valid && !first_valid_seen) begin
        first_valid_seen = 1'b1;
        first_valid_cyc  = cyc;
      end
      if (out_valid && out_ready) begin
        out_q.push_back({out_last, out_data});
        out_cyc_q.push_back(cyc);
      end
      if ((int'(cmd_ready) + int'(in_ready) + int'(out_valid)) > 1) mutex_viol++;
      if (stall_prev && (!out_valid || out_data != stall_data || rsa_addr != stall_addr)) stall_viol++;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_addr = rsa_addr;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Result-stream sink: always ready, random, or one 10-cycle stall after byte 10.
  always @(posedge clk) begin
    #1;
    if (ordy_mode == 0) begin
      out_ready = 1'b1;
    end else if (ordy_mode == 1) begin
      out_ready = ($urandom_range(0, 2) != 0);
    end else begin
      if (out_q.size() == 10 && hold_cnt < 10) begin
        out_ready = 1'b0;
        hold_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    we_q.delete();
    we_cyc_q.delete();
    out_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic issue_cmd(input logic [1:0] op);
    int t = 0;
    while (!cmd_ready && t < 2000) begin
      tick();
      t++;
    end
    chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_valid = 1'b1;
    acc_edge  = cyc + 1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // gap: 0 none, 1 idle cycle before every byte, 2 random idles.
  task automatic send_bytes(input int gap);
    for (int i = 0; i < 32; i++) begin
      int t = 0;
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        tick();
      end
      while (!in_ready && t < 100) begin
        tick();
        t++;
      end
      if (t >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b1;
      in_data  = tx[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [1:0] sel);
    int errs = 0;
    chk({tag, "_we_count"}, 32'(we_q.size()), 32'd32);
    for (int i = 0; i < we_q.size(); i++) begin
      if (i >= 32 || we_q[i] !== {sel, 5'(i), tx[i]}) errs++;
    end
    chk({tag, "_we_content"}, 32'(errs), 32'd0);
  endtask

  task automatic read_and_check(input string tag);
    int t = 0;
    int errs_d = 0, errs_l = 0;
    while (out_q.size() < 32 && t < 3000) begin
      tick();
      t++;
    end
    chk({tag, "_rd_count"}, 32'(out_q.size()), 32'd32);
    for (int i = 0; i < out_q.size() && i < 32; i++) begin
      if (out_q[i][7:0] !== core_mem[i]) errs_d++;
      if (out_q[i][8] !== (i == 31)) errs_l++;
    end
    chk({tag, "_rd_data"}, 32'(errs_d), 32'd0);
    chk({tag, "_rd_last"}, 32'(errs_l), 32'd0);
    tick();
    tick();
    chk({tag, "_idle_after_rd"}, 32'({cmd_ready, busy, rsa_oe, out_valid}), 32'b1000);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      tx[i]       = 8'($urandom);
      core_mem[i] = 8'($urandom);
    end
  endtask

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "time bound exceeded");
  end

  initial begin
    int sn;
    // Reset state.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes_in_reset", 32'({rsa_we, rsa_oe, rsa_start, in_ready, out_valid, out_last, busy, err}), 32'd0);
    chk("rst_cmd_ready_in_reset", 32'(cmd_ready), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_strobes", 32'({rsa_we, rsa_oe, rsa_start, in_ready, out_valid, busy, err}), 32'd0);
    chk("rst_busses", 32'({rsa_reg_sel, rsa_addr, rsa_wdata, out_data}), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Op 0: bytes 0..31, no gaps.
    fill_random();
    for (int i = 0; i < 32; i++) tx[i] = 8'(i);
    clear_logs();
    sn = start_n;
    issue_cmd(2'd0);
    chk("op0_busy", 32'({busy, cmd_ready, in_ready}), 32'b101);
    send_bytes(0);
    tick();
    check_writes("op0", 2'd3);
    if (we_cyc_q.size() == 32) chk("op0_consecutive", 32'(we_cyc_q[31] - we_cyc_q[0]), 32'd31);
    chk("op0_we_latency", 32'(we_cyc_q.size() > 0 ? we_cyc_q[0] - acc_edge : -1), 32'd1);
    chk("op0_idle", 32'({cmd_ready, busy}), 32'b10);
    chk("op0_no_start", 32'(start_n - sn), 32'd0);

    // Op 1: random bytes with random gaps.
    fill_random();
    clear_logs();
    issue_cmd(2'd1);
    send_bytes(2);
    tick();
    check_writes("op1", 2'd2);
    chk("op1_idle", 32'({cmd_ready, busy}), 32'b10);

    // Op 2: in_valid toggled every other cycle, ready 500 cycles after start.
    fill_random();
    clear_logs();
    sn = start_n;
    ordy_mode = 0;
    issue_cmd(2'd2);
    send_bytes(1);
    repeat (3) tick();
    check_writes("op2a", 2'd1);
    chk("op2a_start_once", 32'(start_n - sn), 32'd1);
    chk("op2a_start_fields", 32'(start_viol), 32'd0);
    if (we_cyc_q.size() == 32) chk("op2a_start_after_last", 32'(start_cyc - we_cyc_q[31]), 32'd1);
    repeat (500) tick();
    chk("op2a_wait_no_oe", 32'({rsa_oe, out_valid, busy}), 32'b001);
    first_valid_seen = 1'b0;
    rise_cyc  = cyc;
    rsa_ready = 1'b1;
    read_and_check("op2a");
    chk("op2a_edge_to_valid", 32'(first_valid_cyc - rise_cyc), 32'd3);
    if (out_cyc_q.size() == 32) chk("op2a_read_rate", 32'(out_cyc_q[31] - out_cyc_q[0]), 32'd93);

    // Op 2 with rsa_ready left high; stall the reader mid-stream.
    fill_random();
    clear_logs();
    issue_cmd(2'd2);
    send_bytes(0);
    repeat (2) tick();
    check_writes("op2b", 2'd1);
    chk("op2b_cmd_to_start", 32'(start_cyc - acc_edge), 32'd33);
    oe_seen = 0;
    repeat (100) tick();
    chk("op2b_no_early_exit", 32'(oe_seen), 32'd0);
    chk("op2b_still_busy", 32'(busy), 32'd1);
    rsa_ready = 1'b0;
    repeat (5) tick();
    hold_cnt  = 0;
    ordy_mode = 2;
    first_valid_seen = 1'b0;
    rise_cyc  = cyc;
    rsa_ready = 1'b1;
    read_and_check("op2b");
    chk("op2b_edge_to_valid", 32'(first_valid_cyc - rise_cyc), 32'd3);
    chk("op2b_stall_cycles", 32'(hold_cnt), 32'd10);
    chk("op2b_stall_stable", 32'(stall_viol), 32'd0);

    // Op 3: read only with random backpressure.
    rsa_ready = 1'b0;
    fill_random();
    clear_logs();
    ordy_mode = 1;
    issue_cmd(2'd3);
    read_and_check("op3");
    chk("op3_no_writes", 32'(we_q.size()), 32'd0);
    chk("op3_stall_stable", 32'(stall_viol), 32'd0);

    // Asynchronous reset in the middle of a load.
    ordy_mode = 0;
    fill_random();
    issue_cmd(2'd0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = tx[i];
      tick();
    end
    reset = 1'b0;
    #1;
    chk("midrst_strobes", 32'({rsa_we, rsa_oe, rsa_start, in_ready, out_valid, busy}), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    clear_logs();
    issue_cmd(2'd3);
    read_and_check("postrst");

`ifdef RSA_HOST_TIMEOUT_EN
    // Watchdog: ready never rises.
    begin
      int t = 0;
      int err_cyc;
      rsa_ready = 1'b0;
      fill_random();
      clear_logs();
      issue_cmd(2'd2);
      send_bytes(0);
      while (!err && t < 600) begin
        tick();
        t++;
      end
      err_cyc = cyc;
      chk("tmo_err_set", 32'(err), 32'd1);
      chk("tmo_latency", 32'(err_cyc - start_cyc), 32'd255);
      chk("tmo_idle", 32'({cmd_ready, busy, rsa_oe}), 32'b100);
      issue_cmd(2'd0);
      chk("tmo_err_cleared", 32'(err), 32'd0);
      send_bytes(0);
      tick();
    end
`endif

    chk("err_final", 32'(err), 32'd0);
    chk("handshake_mutex", 32'(mutex_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
